serial_tx: RTL and testbench

//   Parallel-in, serial-out framed transmitter (PISO). A parallel word is

---
 rtl/serial_tx_if.sv | 31 +++
 rtl/serial_tx.sv | 122 ++++++++++++
 tb/tb_serial_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_if.sv
// Bundle of the parallel-load handshake and serial line signals for serial_tx.
// The master side (datapath / host) drives the word and the load request.
// The slave side (the transmitter) reports ready/busy and drives the line.
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             busy;
    logic             tx;
    logic             done;

    modport master (
        output din,
        output load,
        input  ready,
        input  busy,
        input  tx,
        input  done
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output busy,
        output tx,
        output done
    );
endinterface

// File: rtl/serial_tx.sv
// Framed parallel-in / serial-out transmitter.
// A word is accepted when load and ready are both high at a clock edge, then
// sent LSB-first as: start bit (0), WIDTH data bits, stop bit (1).
// Each bit lasts DIV clocks. The line is driven from a flop. All status
// outputs decode registered state only, so no input reaches an output
// combinationally.
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input logic       clk,
    input logic       rst,
    serial_tx_if.slave bus
);
    // Counters need at least one bit, even when DIV or WIDTH is 1.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [BIT_W-1:0] bit_q, bit_n;
    logic [WIDTH-1:0] shreg_q, shreg_n;
    logic             tx_q, tx_n;
    logic             done_q, done_n;
    logic             div_end;

    assign div_end = (div_q == DIV_LAST);

    // State register; a synchronous reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

    // Next-state logic; the line value is derived from the next state so tx stays a pure flop.
    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        done_n  = 1'b0;
        tx_n    = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_n = START;
                    shreg_n = bus.din;
                    div_n   = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (div_end) begin
                    div_n   = '0;
                    state_n = DATA;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_end) begin
                    div_n   = '0;
                    shreg_n = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            STOP: begin
                if (div_end) begin
                    div_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.tx    = tx_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx. One DUT uses the default WIDTH=8/DIV=4,
// a second uses DIV=1 for the one-bit-per-clock case. Every task drives its
// own stimulus and compares observed outputs against hand-written frames.
// Outputs are sampled 1 time unit after each rising edge; inputs change at
// the same point, so they are seen by the following edge.
module tb_serial_tx;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    serial_tx_if #(.WIDTH(8)) bus4 ();
    serial_tx_if #(.WIDTH(8)) bus1 ();

    serial_tx #(.WIDTH(8), .DIV(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    serial_tx #(.WIDTH(8), .DIV(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and move to the sampling point just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_compared++;
        if (bus4.tx !== 1'b1 || bus4.ready !== 1'b1 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: tx/ready/busy/done = %b%b%b%b, required 1100",
                     bus4.tx, bus4.ready, bus4.busy, bus4.done);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_compared++;
            if (bus4.tx !== 1'b1 || bus4.done !== 1'b0 || bus4.ready !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL idle_line cycle %0d: tx=%b done=%b ready=%b, required 1 0 1",
                         c, bus4.tx, bus4.done, bus4.ready);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] frame;
        frame = 10'b1_10100101_0;
        bus4.din  = 8'hA5;
        bus4.load = 1'b1;
        tick();
        bus4.load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            n_compared++;
            if (bus4.tx !== frame[c/4] || bus4.ready !== 1'b0 || bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL a5_frame cycle %0d: tx=%b ready=%b busy=%b done=%b, required tx=%b 0 1 0",
                         c, bus4.tx, bus4.ready, bus4.busy, bus4.done, frame[c/4]);
            end
            tick();
        end
        n_compared++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1 || bus4.tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL a5_done: done=%b ready=%b tx=%b, required 1 1 1",
                     bus4.done, bus4.ready, bus4.tx);
        end
        tick();
        n_compared++;
        if (bus4.done !== 1'b0 || bus4.ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL a5_done_single: done=%b ready=%b, required 0 1", bus4.done, bus4.ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] frame_a;
        logic [9:0] frame_b;
        frame_a = 10'b1_00111100_0;
        frame_b = 10'b1_11111111_0;
        bus4.din  = 8'h3C;
        bus4.load = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            n_compared++;
            if (bus4.tx !== frame_a[c/4] || bus4.done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_first cycle %0d: tx=%b done=%b, required %b 0",
                         c, bus4.tx, bus4.done, frame_a[c/4]);
            end
            tick();
        end
        n_compared++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_done_first: done=%b ready=%b, required 1 1", bus4.done, bus4.ready);
        end
        bus4.din = 8'hFF;
        tick();
        for (int c = 0; c < 40; c++) begin
            n_compared++;
            if (bus4.tx !== frame_b[c/4] || bus4.done !== 1'b0 || bus4.busy !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_second cycle %0d: tx=%b done=%b busy=%b, required %b 0 1",
                         c, bus4.tx, bus4.done, bus4.busy, frame_b[c/4]);
            end
            tick();
        end
        n_compared++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_done_second: done=%b ready=%b, required 1 1", bus4.done, bus4.ready);
        end
        bus4.load = 1'b0;
        tick();
        n_compared++;
        if (bus4.done !== 1'b0 || bus4.ready !== 1'b1 || bus4.tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_idle_after: done=%b ready=%b tx=%b, required 0 1 1",
                     bus4.done, bus4.ready, bus4.tx);
        end
    endtask

    task automatic test_load_while_busy();
        logic [9:0] frame;
        frame = 10'b1_11000011_0;
        bus4.din  = 8'hC3;
        bus4.load = 1'b1;
        tick();
        bus4.load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            n_compared++;
            if (bus4.tx !== frame[c/4] || bus4.ready !== 1'b0 || bus4.done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL busy_load cycle %0d: tx=%b ready=%b done=%b, required %b 0 0",
                         c, bus4.tx, bus4.ready, bus4.done, frame[c/4]);
            end
            if (c == 13) begin
                bus4.din  = 8'h00;
                bus4.load = 1'b1;
            end
            if (c == 14) begin
                bus4.load = 1'b0;
            end
            tick();
        end
        n_compared++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL busy_load_done: done=%b ready=%b, required 1 1", bus4.done, bus4.ready);
        end
        tick();
        n_compared++;
        if (bus4.ready !== 1'b1 || bus4.tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL busy_load_not_queued: ready=%b tx=%b, required 1 1", bus4.ready, bus4.tx);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        frame = 10'b1_10000001_0;
        bus4.din  = 8'hFF;
        bus4.load = 1'b1;
        tick();
        bus4.load = 1'b0;
        for (int c = 0; c < 17; c++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_compared++;
        if (bus4.tx !== 1'b1 || bus4.ready !== 1'b1 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_state: tx/ready/busy/done = %b%b%b%b, required 1100",
                     bus4.tx, bus4.ready, bus4.busy, bus4.done);
        end
        for (int c = 0; c < 45; c++) begin
            tick();
            n_compared++;
            if (bus4.done !== 1'b0 || bus4.tx !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL abort_no_done cycle %0d: done=%b tx=%b, required 0 1",
                         c, bus4.done, bus4.tx);
            end
        end
        bus4.din  = 8'h81;
        bus4.load = 1'b1;
        tick();
        bus4.load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            n_compared++;
            if (bus4.tx !== frame[c/4] || bus4.done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL after_abort cycle %0d: tx=%b done=%b, required %b 0",
                         c, bus4.tx, bus4.done, frame[c/4]);
            end
            tick();
        end
        n_compared++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL after_abort_done: done=%b ready=%b, required 1 1", bus4.done, bus4.ready);
        end
    endtask

    task automatic test_div_one();
        bus1.din  = 8'h00;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        for (int c = 0; c < 9; c++) begin
            n_compared++;
            if (bus1.tx !== 1'b0 || bus1.done !== 1'b0 || bus1.ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL div1_low cycle %0d: tx=%b done=%b ready=%b, required 0 0 0",
                         c, bus1.tx, bus1.done, bus1.ready);
            end
            tick();
        end
        n_compared++;
        if (bus1.tx !== 1'b1 || bus1.done !== 1'b0 || bus1.ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL div1_stop: tx=%b done=%b ready=%b, required 1 0 0",
                     bus1.tx, bus1.done, bus1.ready);
        end
        tick();
        n_compared++;
        if (bus1.done !== 1'b1 || bus1.ready !== 1'b1 || bus1.tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL div1_done: done=%b ready=%b tx=%b, required 1 1 1",
                     bus1.done, bus1.ready, bus1.tx);
        end
        tick();
        n_compared++;
        if (bus1.done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL div1_done_single: done=%b, required 0", bus1.done);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        bus4.din     = '0;
        bus4.load    = 1'b0;
        bus1.din     = '0;
        bus1.load    = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_frame();
        test_div_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
